// File: rtl/rnd_gen_n8_if.sv
// Seed/request/randomness bundle between the xorshift source and its consumer.
// Latency: none (wires only).
// Backpressure: the consumer throttles the stream with rnd_req; there is no rdy on rnd.
//
// Signals:
//   seed_vld, seed_in : serial seed words, lane 0 first
//   reseed            : restart seeding from lane 0
//   rnd_req           : consumer takes the current rnd word set
//   rnd, rnd_vld      : RANDNUM lanes of K_WIDTH bits, zero unless rnd_vld
//   busy              : seeding or warm-up in progress
interface rnd_gen_n8_if #(
    parameter int K_WIDTH = 32,
    parameter int RANDNUM = 12
);
    logic                         seed_vld;
    logic [K_WIDTH-1:0]           seed_in;
    logic                         reseed;
    logic                         rnd_req;
    logic [K_WIDTH*RANDNUM-1:0]   rnd;
    logic                         rnd_vld;
    logic                         busy;

    // Consumer / seeding side.
    modport master (
        output seed_vld,
        output seed_in,
        output reseed,
        output rnd_req,
        input  rnd,
        input  rnd_vld,
        input  busy
    );

    // Randomness generator side.
    modport slave (
        input  seed_vld,
        input  seed_in,
        input  reseed,
        input  rnd_req,
        output rnd,
        output rnd_vld,
        output busy
    );
endinterface

// File: rtl/rnd_gen_n8.sv
// Parallel xorshift32 source feeding the rnd bus of the 8-share full-XOR unmasking stage.
// Latency: rnd_vld rises RANDNUM+WARMUP edges after the first seed edge; a new word set 1 cycle after each rnd_req.
// Backpressure: lanes only advance on rnd_req in RUN; ena=0 freezes everything.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (zeroes lanes, returns to IDLE)
//   ena    : global enable, shared with the consumer stage
//   bus    : rnd_gen_n8_if.slave (seed_vld/seed_in/reseed/rnd_req in, rnd/rnd_vld/busy out)
module rnd_gen_n8 #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 8,
    parameter int LOG_K    = $clog2(N_SHARES + 1) - 1,
    parameter int RANDNUM  = (N_SHARES == 1) ? 0
                             : LOG_K * 2**(LOG_K - 1) + N_SHARES - 2**LOG_K,
    parameter int WARMUP   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    rnd_gen_n8_if.slave   bus
);

    localparam int CW = 4;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam logic [K_WIDTH-1:0] SEED_FIX = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WW-1:0]      wcnt_q;
    logic               busy_q;
    logic               vld_q;
    logic [K_WIDTH-1:0] lane_q [RANDNUM];

    // Lane that the next accepted seed word lands in, and whether it is the last one.
    logic [CW-1:0]      seed_idx;
    logic               seed_last;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    always_comb begin
        seed_idx  = (state_q == IDLE) ? '0 : cnt_q;
        seed_last = (seed_idx == CW'(RANDNUM - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            for (int j = 0; j < RANDNUM; j++) begin
                lane_q[j] <= '0;
            end
        end else if (ena) begin
            if (bus.reseed) begin
                // Reseed beats seed_vld and rnd_req; lanes keep their old values until overwritten.
                state_q <= SEED;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                vld_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, SEED: begin
                        if (bus.seed_vld) begin
                            for (int j = 0; j < RANDNUM; j++) begin
                                if (CW'(j) == seed_idx) begin
                                    // A zero seed would lock xorshift at zero forever.
                                    lane_q[j] <= (bus.seed_in == '0) ? (SEED_FIX ^ K_WIDTH'(j))
                                                                     : bus.seed_in;
                                end
                            end
                            cnt_q <= seed_idx + 1'b1;
                            if (seed_last) begin
                                if (WARMUP == 0) begin
                                    state_q <= RUN;
                                    busy_q  <= 1'b0;
                                    vld_q   <= 1'b1;
                                end else begin
                                    state_q <= WARM;
                                    wcnt_q  <= WW'(WARMUP);
                                    busy_q  <= 1'b1;
                                end
                            end else begin
                                state_q <= SEED;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    WARM: begin
                        for (int j = 0; j < RANDNUM; j++) begin
                            lane_q[j] <= xs32(lane_q[j]);
                        end
                        wcnt_q <= wcnt_q - 1'b1;
                        if (wcnt_q == WW'(1)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                            vld_q   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.rnd_req) begin
                            for (int j = 0; j < RANDNUM; j++) begin
                                lane_q[j] <= xs32(lane_q[j]);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Lane values are only exposed in RUN so seed and warm-up material never leaks.
    always_comb begin
        bus.rnd = '0;
        if (vld_q) begin
            for (int j = 0; j < RANDNUM; j++) begin
                bus.rnd[j*K_WIDTH +: K_WIDTH] = lane_q[j];
            end
        end
    end

    assign bus.rnd_vld = vld_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rnd_gen_n8.sv
// Self-checking bench: two generators (WARMUP=1 and WARMUP=0) share one stimulus stream.
// Latency: expected values come from a lane-level xorshift model updated per accepted edge.
// Backpressure: rnd_req and ena are randomised to exercise hold and advance.
module tb_rnd_gen_n8;

    localparam int KW = 32;
    localparam int RN = 12;
    localparam int VW = KW * RN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        seed_vld;
    logic [31:0] seed_in;
    logic        reseed;
    logic        rnd_req;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected lane contents of the WARMUP=1 (m1) and WARMUP=0 (m0) instances.
    logic [VW-1:0] m1;
    logic [VW-1:0] m0;

    always #5 clk = ~clk;

    rnd_gen_n8_if #(.K_WIDTH(KW), .RANDNUM(RN)) if1 ();
    rnd_gen_n8_if #(.K_WIDTH(KW), .RANDNUM(RN)) if0 ();

    assign if1.seed_vld = seed_vld;
    assign if1.seed_in  = seed_in;
    assign if1.reseed   = reseed;
    assign if1.rnd_req  = rnd_req;
    assign if0.seed_vld = seed_vld;
    assign if0.seed_in  = seed_in;
    assign if0.reseed   = reseed;
    assign if0.rnd_req  = rnd_req;

    rnd_gen_n8 #(.WARMUP(1)) u_dut_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (if1)
    );

    rnd_gen_n8 #(.WARMUP(0)) u_dut_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (if0)
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [VW-1:0] step_all(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int j = 0; j < RN; j++) r[j*KW +: KW] = xs(v[j*KW +: KW]);
        return r;
    endfunction

    function automatic logic [31:0] fixz(input logic [31:0] w, input int j);
        return (w == 32'd0) ? (32'h9E3779B9 ^ 32'(j)) : w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; seed_vld = 1'b0; seed_in = '0; reseed = 1'b0; rnd_req = 1'b0;
        #3;
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL reset_w1: got vld=%b busy=%b rnd=%h, want all zero", if1.rnd_vld, if1.busy, if1.rnd);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL reset_w0: got vld=%b busy=%b rnd=%h, want all zero", if0.rnd_vld, if0.busy, if0.rnd);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) tick();
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL idle_w1: got vld=%b busy=%b, want idle zeros", if1.rnd_vld, if1.busy);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL idle_w0: got vld=%b busy=%b, want idle zeros", if0.rnd_vld, if0.busy);
        end
    endtask

    task automatic test_seed_warmup();
        for (int j = 0; j < RN; j++) begin
            seed_vld = 1'b1;
            seed_in  = 32'(j + 1);
            rnd_req  = 1'b1;           // ignored while seeding
            tick();
            if (j < RN - 1) begin
                n_chk++;
                if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b01}) begin
                    n_fail++; $display("FAIL seeding_w1 word %0d: got vld=%b busy=%b, want vld=0 busy=1", j, if1.rnd_vld, if1.busy);
                end
                n_chk++;
                if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b01}) begin
                    n_fail++; $display("FAIL seeding_w0 word %0d: got vld=%b busy=%b, want vld=0 busy=1", j, if0.rnd_vld, if0.busy);
                end
            end
        end
        seed_vld = 1'b0;
        rnd_req  = 1'b0;
        for (int j = 0; j < RN; j++) m0[j*KW +: KW] = fixz(32'(j + 1), j);
        m1 = m0;
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b01}) begin
            n_fail++; $display("FAIL warm_w1: got vld=%b busy=%b, want vld=0 busy=1", if1.rnd_vld, if1.busy);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {m0, 2'b10}) begin
            n_fail++; $display("FAIL run_nowarm_w0: got %h vld=%b busy=%b, want %h vld=1 busy=0", if0.rnd, if0.rnd_vld, if0.busy, m0);
        end
        tick();
        m1 = step_all(m1);
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {m1, 2'b10}) begin
            n_fail++; $display("FAIL run_after_warm_w1: got %h vld=%b busy=%b, want %h vld=1 busy=0", if1.rnd, if1.rnd_vld, if1.busy, m1);
        end
        n_chk++;
        if (if1.rnd[31:0] !== 32'h00042021) begin
            n_fail++; $display("FAIL warm_lane0_w1: got %h want 00042021", if1.rnd[31:0]);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld} !== {m0, 1'b1}) begin
            n_fail++; $display("FAIL idle_run_w0: got %h want %h", if0.rnd, m0);
        end
    endtask

    task automatic test_req_handshake();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if ({if1.rnd, if1.rnd_vld} !== {m1, 1'b1}) begin
                n_fail++; $display("FAIL hold_w1 cycle %0d: got %h want %h", c, if1.rnd, m1);
            end
            n_chk++;
            if ({if0.rnd, if0.rnd_vld} !== {m0, 1'b1}) begin
                n_fail++; $display("FAIL hold_w0 cycle %0d: got %h want %h", c, if0.rnd, m0);
            end
        end
        rnd_req = 1'b1;
        tick();
        rnd_req = 1'b0;
        m1 = step_all(m1);
        m0 = step_all(m0);
        n_chk++;
        if (if0.rnd[31:0] !== 32'h00042021) begin
            n_fail++; $display("FAIL pulse_lane0_w0: got %h want 00042021", if0.rnd[31:0]);
        end
        n_chk++;
        if ({if1.rnd, if1.rnd_vld} !== {m1, 1'b1}) begin
            n_fail++; $display("FAIL pulse_w1: got %h want %h", if1.rnd, m1);
        end
        tick();
        n_chk++;
        if ({if0.rnd, if0.rnd_vld} !== {m0, 1'b1}) begin
            n_fail++; $display("FAIL pulse_once_w0: got %h want %h", if0.rnd, m0);
        end
        for (int c = 0; c < 20; c++) begin
            rnd_req = 1'b1;
            ena     = ($urandom_range(0, 3) != 0);
            tick();
            if (ena) begin
                m1 = step_all(m1);
                m0 = step_all(m0);
            end
            n_chk++;
            if ({if1.rnd, if1.rnd_vld} !== {m1, 1'b1}) begin
                n_fail++; $display("FAIL stream_w1 cycle %0d ena=%b: got %h want %h", c, ena, if1.rnd, m1);
            end
            n_chk++;
            if ({if0.rnd, if0.rnd_vld} !== {m0, 1'b1}) begin
                n_fail++; $display("FAIL stream_w0 cycle %0d ena=%b: got %h want %h", c, ena, if0.rnd, m0);
            end
        end
        ena     = 1'b1;
        rnd_req = 1'b0;
    endtask

    task automatic test_reseed();
        logic [VW-1:0] nm;
        logic [31:0]   w;
        int            k;
        int            cyc;
        reseed   = 1'b1;
        seed_vld = 1'b1;
        seed_in  = $urandom;
        rnd_req  = 1'b1;
        tick();
        reseed   = 1'b0;
        seed_vld = 1'b0;
        rnd_req  = 1'b0;
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b01}) begin
            n_fail++; $display("FAIL reseed_w1: got vld=%b busy=%b rnd=%h, want vld=0 busy=1 rnd=0", if1.rnd_vld, if1.busy, if1.rnd);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b01}) begin
            n_fail++; $display("FAIL reseed_w0: got vld=%b busy=%b rnd=%h, want vld=0 busy=1 rnd=0", if0.rnd_vld, if0.busy, if0.rnd);
        end
        nm  = '0;
        k   = 0;
        cyc = 0;
        while (k < RN && cyc < 400) begin
            ena      = ($urandom_range(0, 3) != 0);
            seed_vld = ($urandom_range(0, 2) != 0);
            rnd_req  = ($urandom_range(0, 1) != 0);
            w        = $urandom;
            if (k == 3) w = 32'd0;
            seed_in  = w;
            if (ena && seed_vld) begin
                nm[k*KW +: KW] = fixz(w, k);
                k++;
            end
            tick();
            cyc++;
            if (k < RN) begin
                n_chk++;
                if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b01}) begin
                    n_fail++; $display("FAIL reseeding_w0 word %0d: got vld=%b busy=%b, want vld=0 busy=1", k, if0.rnd_vld, if0.busy);
                end
            end
        end
        n_chk++;
        if (k < RN) begin
            n_fail++; $display("FAIL reseed_budget: only %0d of %0d words in %0d cycles", k, RN, cyc);
        end
        ena      = 1'b1;
        seed_vld = 1'b0;
        rnd_req  = 1'b0;
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {nm, 2'b10}) begin
            n_fail++; $display("FAIL reseed_run_w0: got %h vld=%b, want %h vld=1", if0.rnd, if0.rnd_vld, nm);
        end
        n_chk++;
        if (if0.rnd[3*KW +: KW] !== 32'h9E3779BA) begin
            n_fail++; $display("FAIL zero_seed_lane3: got %h want 9e3779ba", if0.rnd[3*KW +: KW]);
        end
        ena      = 1'b0;
        rnd_req  = 1'b1;
        seed_vld = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b01}) begin
                n_fail++; $display("FAIL warm_freeze_w1 cycle %0d: got vld=%b busy=%b, want vld=0 busy=1", c, if1.rnd_vld, if1.busy);
            end
            n_chk++;
            if ({if0.rnd, if0.rnd_vld} !== {nm, 1'b1}) begin
                n_fail++; $display("FAIL run_freeze_w0 cycle %0d: got %h want %h", c, if0.rnd, nm);
            end
        end
        ena      = 1'b1;
        rnd_req  = 1'b0;
        seed_vld = 1'b0;
        tick();
        m1 = step_all(nm);
        m0 = nm;
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {m1, 2'b10}) begin
            n_fail++; $display("FAIL reseed_warm_w1: got %h vld=%b busy=%b, want %h vld=1 busy=0", if1.rnd, if1.rnd_vld, if1.busy, m1);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld} !== {m0, 1'b1}) begin
            n_fail++; $display("FAIL reseed_hold_w0: got %h want %h", if0.rnd, m0);
        end
    endtask

    task automatic test_reset_mid_run();
        rnd_req = 1'b1;
        tick();
        rnd_req = 1'b0;
        m1 = step_all(m1);
        m0 = step_all(m0);
        n_chk++;
        if ({if1.rnd, if1.rnd_vld} !== {m1, 1'b1}) begin
            n_fail++; $display("FAIL pre_reset_w1: got %h want %h", if1.rnd, m1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({if1.rnd, if1.rnd_vld, if1.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL async_reset_w1: got vld=%b busy=%b rnd=%h, want all zero", if1.rnd_vld, if1.busy, if1.rnd);
        end
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL async_reset_w0: got vld=%b busy=%b rnd=%h, want all zero", if0.rnd_vld, if0.busy, if0.rnd);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if ({if0.rnd, if0.rnd_vld, if0.busy} !== {{VW{1'b0}}, 2'b00}) begin
            n_fail++; $display("FAIL post_reset_idle_w0: got vld=%b busy=%b, want idle zeros", if0.rnd_vld, if0.busy);
        end
    endtask

    initial begin
        test_reset();
        test_seed_warmup();
        test_req_handshake();
        test_reseed();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rnd_gen_n8.md
# rnd_gen_n8

Parallel xorshift32 randomness source that supplies the `rnd` bus of the 8-share masked full-XOR unmasking stage: one 32-bit fresh word per refresh gadget (RANDNUM = 12 words for N_SHARES = 8) per consumed cycle. It sits directly upstream of that stage and shares its `clk`, `rst_n` and `ena`. It provides:

- serial seed loading,
- a configurable warm-up phase,
- a request/valid handshake, so the consumer advances the stream only when it actually uses a word set.

## Interface
- `K_WIDTH`, 32: lane width; fixed at 32 (xorshift32 constants); other values unsupported.
- `N_SHARES`, 8: share count of the consumer.
- `LOG_K`, `$clog2(N_SHARES+1)-1`: derived.
- `RANDNUM`, `(N_SHARES==1) ? 0 : LOG_K*2**(LOG_K-1)+N_SHARES-2**LOG_K`: lane count (12 for N_SHARES = 8).
- `WARMUP`, 16: lane steps discarded after seeding; 0 allowed.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: global enable; when low all state holds, all inputs ignored.
- `seed_vld` input 1: `seed_in` carries the next seed word.
- `seed_in` input K_WIDTH: seed word; lane index = order of arrival (lane 0 first).
- `reseed` input 1: restart seeding from lane 0.
- `rnd_req` input 1: consumer takes the current `rnd`; advance all lanes.
- `rnd` output K_WIDTH*RANDNUM: lane j on bits [j*K_WIDTH +: K_WIDTH]; all-zero unless `rnd_vld`.
- `rnd_vld` output 1: `rnd` is valid fresh randomness.
- `busy` output 1: seeding or warm-up in progress.

## Operation
- **FSM states:** IDLE, SEED, WARM, RUN. The state, a 4-bit lane counter `cnt` and a warm counter `wcnt` are registers. Every transition below requires `ena` = 1.
- **Lane step:** `x ^= x<<13; x ^= x>>17; x ^= x<<5` on 32 bits. All lanes step together.
- **Seed capture:** a written seed word of 0 is replaced by `32'h9E3779B9 ^ j` for lane j, so no lane is ever stuck at zero.
- **IDLE:**
  - `seed_vld`: capture `seed_in` into lane 0; `cnt` = 1; go to SEED.
  - If RANDNUM = 1, apply the last-word rule below instead.
- **SEED:**
  - `seed_vld`: capture into lane `cnt`; `cnt`++.
  - On the word for lane RANDNUM-1: go to WARM with `wcnt` = WARMUP, or go straight to RUN if WARMUP = 0.
- **WARM:**
  - Each cycle: step all lanes; `wcnt`--.
  - The step that brings `wcnt` to 0 also moves the state to RUN.
  - `seed_vld` is ignored.
- **RUN:**
  - `rnd` = concatenation of the lanes; `rnd_vld` = 1.
  - `rnd_req`: step all lanes, so the next cycle shows a new word set.
  - `rnd_req` outside RUN is ignored.
- **`reseed` (any state, `ena` = 1):**
  - Go to SEED with `cnt` = 0. A `seed_vld` in the same cycle is ignored (reseed wins).
  - Lane contents are kept until overwritten.
  - `rnd_vld` falls the next cycle.
- **Decoded outputs:**
  - `busy` = (state == SEED) or (state == WARM).
  - `rnd_vld` = (state == RUN).
  - `rnd` is gated to zero whenever `rnd_vld` = 0, so seed or warm-up values never leak.

## Timing
- **Reset (asynchronous assert):**
  - State = IDLE; all lanes, `cnt` and `wcnt` = 0.
  - `rnd` = 0, `rnd_vld` = 0, `busy` = 0.
  - Release is synchronous to the next edge.
- **Seeding latency:** with `ena` held high and back-to-back `seed_vld`, lane words are captured on edges 1..RANDNUM.
- **Warm-up latency:** WARM is occupied for WARMUP cycles. `rnd_vld` rises RANDNUM + WARMUP edges after the first seed edge (RANDNUM edges if WARMUP = 0).
- **`seed_vld` gaps:** gaps or `ena` = 0 cycles stretch SEED without losing words.
- **`ena` = 0:** WARM pauses, and `rnd` holds its value in RUN.
- **Stream advance in RUN:** a `rnd_req` accepted at edge t shows new `rnd` after t. `rnd_req` held high gives a new word set every cycle (throughput 1/cycle).
- **`rnd_req` with `reseed`:** `rnd_req` together with `reseed` does not step the lanes.
- **Reset mid-operation:** returns to IDLE. Any partial seed is discarded and lanes are zeroed.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-RUN -> `rnd` = 0, `rnd_vld` = 0, `busy` = 0 immediately (before any clock edge).
- **WARMUP = 1, seeds:** seeds lane j = j+1 -> after 12 seed edges `busy` = 1 for 1 cycle, then `rnd_vld` = 1 and lane 0 = 0x00042021.
- **Zero seed:** seed lane 3 = 0, WARMUP = 0 -> RUN lane 3 = 0x9E3779BA.
- **Request handshake:** in RUN hold `rnd_req` = 0 for 5 cycles -> `rnd` constant; pulse `rnd_req` once -> exactly one lane step (lane 0 value 1 -> 0x00042021 when WARMUP = 0).
- **`ena` gating:** drop `ena` during WARM and SEED -> counters and lanes freeze; `seed_vld` words during `ena` = 0 are not captured.
- **Reseed priority:** `reseed` with `seed_vld` and `rnd_req` in RUN -> next cycle `rnd_vld` = 0, `rnd` = 0, `busy` = 1, lanes unstepped, the first later seed word lands in lane 0.
